// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction RAM port, stall/PC-change exchange with the
// instruction-memory FSM, execute redirect and the decode valid/ready handshake.
interface if_fetch_unit_if #(
    parameter int AW = 10
);
    logic          fetch_stall;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_ready;
    logic [AW-1:0] imem_addr;
    logic          pc_changed;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;

    modport master (
        input  fetch_stall, imem_rdata, redirect_valid, redirect_pc, id_ready,
        output imem_addr, pc_changed, if_valid, if_instr, if_pc
    );

    modport slave (
        output fetch_stall, imem_rdata, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, pc_changed, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC owner, 2-entry fetch buffer towards decode, redirect flush.
// Optional performance counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 10
) (
    input  logic        clk,
    input  logic        rstn,
    if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pc_changed;
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_buf_pc    [2];

    logic        w_redirect;
    logic        w_pop;
    logic        w_pop_eff;
    logic        w_capture;
    logic [31:0] w_redirect_target;

    // Redirect outranks everything; a redirect also cancels any same-cycle pop.
    assign w_redirect        = bus.redirect_valid & (r_state != ST_BOOT);
    assign w_pop             = (r_count != 2'd0) & bus.id_ready;
    assign w_pop_eff         = w_pop & ~w_redirect;
    assign w_capture         = (r_state == ST_RUN) & ~bus.fetch_stall & ~w_redirect &
                               ((r_count < 2'd2) | w_pop);
    assign w_redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_addr  = r_pc[AW+1:2];
    assign bus.pc_changed = r_pc_changed;
    assign bus.if_valid   = (r_count != 2'd0);
    assign bus.if_instr   = r_buf_instr[r_rd_ptr];
    assign bus.if_pc      = r_buf_pc[r_rd_ptr];

    // Fetch control FSM: owns the PC and the pc_changed pulse to the memory FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_pc_changed <= 1'b0;
        end else if (w_redirect) begin
            r_state      <= ST_RUN;
            r_pc         <= w_redirect_target;
            r_pc_changed <= 1'b1;
        end else begin
            r_pc_changed <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state      <= ST_RUN;
                    r_pc_changed <= 1'b1;
                end
                ST_RUN: begin
                    if (w_capture) begin
                        r_pc         <= r_pc + 32'd4;
                        r_pc_changed <= 1'b1;
                    end else if (!bus.fetch_stall) begin
                        // Response arrived with nowhere to put it: drop it and re-read later.
                        r_state <= ST_FULL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state      <= ST_RUN;
                        r_pc_changed <= 1'b1;
                    end else begin
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // Circular 2-entry buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (w_redirect) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            case ({w_capture, w_pop_eff})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Buffer storage: written only on a capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_instr[i] <= 32'd0;
                r_buf_pc[i]    <= 32'd0;
            end
        end else if (w_capture) begin
            r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
            r_buf_pc[r_wr_ptr]    <= r_pc;
        end else begin
            r_buf_instr[r_wr_ptr] <= r_buf_instr[r_wr_ptr];
            r_buf_pc[r_wr_ptr]    <= r_buf_pc[r_wr_ptr];
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetch_cnt;
    logic [15:0] r_perf_stall_cnt;

    // Saturating counters: captures, and active cycles with nothing for decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_fetch_cnt <= 16'd0;
            r_perf_stall_cnt <= 16'd0;
        end else begin
            if (w_capture && (r_perf_fetch_cnt != 16'hFFFF)) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 16'd1;
            end else begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt;
            end
            if ((r_state != ST_BOOT) && (r_count == 2'd0) && (r_perf_stall_cnt != 16'hFFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
            end else begin
                r_perf_stall_cnt <= r_perf_stall_cnt;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit: boot, streaming, backpressure,
// redirect, PC wrap, mid-run reset and redirect-during-boot.
module tb_if_fetch_unit;

    logic clk;
    logic rstn;

    if_fetch_unit_if #(.AW(10)) bus ();

`ifdef IF_FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .AW       (10)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fs;
        logic [31:0] rdata;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [9:0]  e_addr;
        logic        e_pcc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic fs, input logic [31:0] rdata, input logic rv,
                                input logic [31:0] rpc, input logic rdy, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [9:0] ea, input logic epcc);
        vec_t v;
        v.fs = fs; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_addr = ea; v.e_pcc = epcc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, clock it, then compare just after the edge.
    task automatic apply(input string tag, input vec_t v);
        bus.fetch_stall    = v.fs;
        bus.imem_rdata     = v.rdata;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        bus.id_ready       = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, " if_valid"},   {31'd0, bus.if_valid},   {31'd0, v.e_valid});
        chk({tag, " imem_addr"},  {22'd0, bus.imem_addr},  {22'd0, v.e_addr});
        chk({tag, " pc_changed"}, {31'd0, bus.pc_changed}, {31'd0, v.e_pcc});
        if (v.e_valid) begin
            chk({tag, " if_instr"}, bus.if_instr, v.e_instr);
            chk({tag, " if_pc"},    bus.if_pc,    v.e_pc);
        end
    endtask

    initial begin
        // Boot with stall held, then streaming fetch with decode always ready.
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd0, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13, 1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h0, 10'd1, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd1, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13, 1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h4, 10'd2, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd2, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13, 1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h8, 10'd3, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd3, 1'b0));
        // Redirect back to 0, then backpressure: two held, third dropped, FULL.
        vecs.push_back(mk(1'b1, 32'h0,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0, 10'd0, 1'b1));
        vecs.push_back(mk(1'b0, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h0, 10'd1, 1'b1));
        vecs.push_back(mk(1'b0, 32'hA1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h0, 10'd2, 1'b1));
        vecs.push_back(mk(1'b0, 32'hA2, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h0, 10'd2, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h0, 10'd2, 1'b0));
        vecs.push_back(mk(1'b0, 32'hA3, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 32'h0, 10'd2, 1'b0));
        // Pop out of FULL: re-read pulse at the same address.
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'hA1, 32'h4, 10'd2, 1'b1));
        vecs.push_back(mk(1'b0, 32'hA2, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA1, 32'h4, 10'd3, 1'b1));
        // Full buffer with pop and capture in the same cycle.
        vecs.push_back(mk(1'b0, 32'hA3, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA2, 32'h8, 10'd4, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'hA3, 32'hC, 10'd4, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'd4, 1'b0));
        // Redirect to 0x103 with a same-cycle response and pop: both dropped.
        vecs.push_back(mk(1'b0, 32'hB0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB0, 32'h10, 10'd5, 1'b1));
        vecs.push_back(mk(1'b0, 32'hBAD, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0, 32'h0, 10'h40, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  32'h0, 10'h40, 1'b0));
        // PC wrap from 0xFFFF_FFFC.
        vecs.push_back(mk(1'b1, 32'h0,  1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 10'h3FF, 1'b1));
        vecs.push_back(mk(1'b0, 32'hC0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 32'hFFFF_FFFC, 10'd0, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 32'hFFFF_FFFC, 10'd0, 1'b0));
        vecs.push_back(mk(1'b0, 32'hC1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 32'hFFFF_FFFC, 10'd1, 1'b1));

        rstn               = 1'b0;
        bus.fetch_stall    = 1'b1;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_valid",   {31'd0, bus.if_valid},   32'd0);
        chk("reset imem_addr",  {22'd0, bus.imem_addr},  32'd0);
        chk("reset pc_changed", {31'd0, bus.pc_changed}, 32'd0);
        chk("reset if_instr",   bus.if_instr,            32'd0);
        chk("reset if_pc",      bus.if_pc,               32'd0);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Mid-run reset with two entries buffered: outputs clear without a clock edge.
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst if_valid",   {31'd0, bus.if_valid},   32'd0);
        chk("midrst imem_addr",  {22'd0, bus.imem_addr},  32'd0);
        chk("midrst pc_changed", {31'd0, bus.pc_changed}, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        chk("midrst perf_fetch", {16'd0, perf_fetch_cnt}, 32'd0);
        chk("midrst perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Redirect while in BOOT is ignored; fetch then starts from RESET_PC.
        apply("bootrd0", mk(1'b1, 32'h0,  1'b1, 32'h200, 1'b0, 1'b0, 32'h0,  32'h0, 10'd0, 1'b1));
        apply("bootrd1", mk(1'b0, 32'hD0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hD0, 32'h0, 10'd1, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RISC-V Lite core. It owns the program counter, drives the word address into the instruction RAM, and consumes the instruction-memory FSM's fetch-stall signal. When the FSM releases the stall it captures the returned word, and it pulses `pc_changed` back to the FSM whenever the PC moves. Fetched instructions go to decode through a 2-entry buffer with a valid/ready handshake, and branch/jump redirects from execute flush the buffer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; bits [1:0] are 0.
- `AW`, default 10: instruction RAM word-address width.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `fetch_stall`  in  1  from the instruction-memory FSM; 0 for one cycle means `imem_rdata` is valid for the current `imem_addr`.
- `imem_rdata`  in  32  instruction RAM read data.
- `redirect_valid`  in  1  PC redirect request from execute (taken branch or jump).
- `redirect_pc`  in  32  redirect target.
- `id_ready`  in  1  decode accepts the buffer head this cycle.
- `imem_addr`  out  AW  equals `pc[AW+1:2]`.
- `pc_changed`  out  1  registered one-cycle pulse; the PC was loaded on the previous edge.
- `if_valid`  out  1  buffer non-empty.
- `if_instr`  out  32  instruction at the buffer head.
- `if_pc`  out  32  PC of the buffer head.

## Operation
- **State machine:** BOOT, RUN, FULL.
- **Capture condition:** capture = state RUN, `fetch_stall`=0, `redirect_valid`=0, and (count<2 or pop this cycle).
- **pop:** `if_valid` & `id_ready`. The head is removed on the edge.
- **BOOT** (reset state):
  - No capture; `pc` = `RESET_PC`.
  - Next cycle: go to RUN and assert `pc_changed`, so the FSM restarts its read.
- **RUN:**
  - On capture: push {pc, imem_rdata}, `pc` <= `pc`+4, `pc_changed` next cycle.
  - If `fetch_stall`=0 but the buffer is full with no pop: discard the data, keep `pc`, go to FULL.
- **FULL:**
  - Wait for pop.
  - On pop: go to RUN and pulse `pc_changed` without changing `pc`, forcing a re-read of the same address.
- **Redirect** (any state except BOOT, highest priority):
  - Buffer emptied on the edge.
  - `pc` <= {`redirect_pc`[31:2], 2'b00}; `pc_changed` next cycle; state RUN.
  - Any same-cycle memory response is dropped; any same-cycle pop is ignored.
- **Redirect during BOOT:** ignored.
- **PC arithmetic:** 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 with no flag.
- **Buffer:** 2-entry circular, 1-bit pointers, 2-bit count. Push and pop in the same cycle leave count unchanged, including when full.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`, `imem_addr` = `RESET_PC[AW+1:2]`.
  - `pc_changed`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - Count 0, state BOOT.
- **Reset mid-operation:** immediate asynchronous return to these values; buffered entries are lost.
- **Capture latency:** `fetch_stall`=0 at edge N -> `if_valid`=1 after edge N (no combinational bypass).
- **pc_changed timing:** `pc_changed` is high exactly during the cycle after the PC register load. `imem_addr` shows the new value in that same cycle.
- **Output stability:** `if_instr`/`if_pc` stay stable while `if_valid`=1 and `id_ready`=0.
- **Combinational paths:** no combinational path from `id_ready` or `redirect_valid` to any output.

## Configuration
- **`IF_FETCH_PERF_CNT_EN` defined:**
  - Adds outputs `perf_fetch_cnt[15:0]` and `perf_stall_cnt[15:0]`.
  - `perf_fetch_cnt` increments per capture.
  - `perf_stall_cnt` increments each cycle in RUN or FULL with `if_valid`=0.
  - Both saturate at 16'hFFFF and reset to 0.
- **Undefined:** those ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Boot:** reset release with `fetch_stall`=1 held -> `pc_changed` high in the 2nd cycle; `imem_addr`=0; `if_valid` stays 0.
- **Sequential fetch:** `fetch_stall`=0 every 2nd cycle, `imem_rdata`=0x00000013, `id_ready`=1 -> decode receives `if_pc` 0x0, 0x4, 0x8 in order, one `pc_changed` per capture.
- **Backpressure:** `id_ready`=0, three responses -> two entries held (PCs 0x0, 0x4), FULL entered, `pc` stays 0x8. Raise `id_ready` -> `pc_changed` pulses with `imem_addr`=2 and fetch resumes.
- **Redirect:** `redirect_valid`=1 with `redirect_pc`=0x0000_0103 in the same cycle as `fetch_stall`=0 -> buffer empty, the response dropped, `pc`=0x100, `imem_addr`=0x40, `pc_changed` pulse next cycle.
- **Wrap:** `redirect_pc`=0xFFFF_FFFC, one capture -> `if_pc`=0xFFFF_FFFC and the next `pc`=0x0.
- **Mid-run reset:** `rstn` low with 2 entries buffered -> `if_valid`=0 immediately; with `IF_FETCH_PERF_CNT_EN` defined, both counters read 0.
